// File: rtl/cis_dvp_capture.sv
// CIS parallel (DVP) port capture: synchronizes the sensor pins into wb_clk_i, frames pixels
// with SOF/EOL markers through a one-pixel hold register and buffers them in a FWFT FIFO.
module cis_dvp_capture #(
  parameter int DW         = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int COL_W      = 12,
  parameter int ROW_W      = 12
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             cis_pclk,
  input  logic             cis_href,
  input  logic             cis_vsync,
  input  logic [DW-1:0]    cis_data,
  input  logic             cap_en,
  output logic [DW-1:0]    pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [ROW_W-1:0] line_cnt,
  output logic [COL_W-1:0] col_cnt_last,
  output logic [7:0]       frame_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DW + 2;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, IN_FRAME} state_t;

  state_t state, state_next;

  logic [2:0]    pclk_sync, href_sync, vs_sync;
  logic [DW-1:0] data_s1, data_s2;
  logic          pclk_rise, href_rise, href_fall, vs_fall, vs_rise;

  logic          frame_start, frame_end, in_frame, capture, line_end;
  logic          line_active, sof_pend;
  logic          hold_valid, hold_sof;
  logic [DW-1:0] hold_data;
  logic [COL_W-1:0] col_cnt;

  logic          push_en, pop, full, empty, accept, drop;
  logic [EW-1:0] push_word, head;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  // Stage [1] is the synchronized level, stage [2] only exists to detect edges.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pclk_sync <= '0;
      href_sync <= '0;
      vs_sync   <= '0;
      data_s1   <= '0;
      data_s2   <= '0;
    end else begin
      pclk_sync <= {pclk_sync[1:0], cis_pclk};
      href_sync <= {href_sync[1:0], cis_href};
      vs_sync   <= {vs_sync[1:0], cis_vsync};
      data_s1   <= cis_data;
      data_s2   <= data_s1;
    end
  end

  assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
  assign href_rise = href_sync[1] & ~href_sync[2];
  assign href_fall = ~href_sync[1] & href_sync[2];
  assign vs_fall   = ~vs_sync[1] & vs_sync[2];
  assign vs_rise   = vs_sync[1] & ~vs_sync[2];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: if (cap_en) state_next = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!cap_en) state_next = IDLE;
        else if (vs_fall) begin
          state_next  = IN_FRAME;
          frame_start = 1'b1;
        end
      end
      IN_FRAME: begin
        if (vs_rise) begin
          frame_end  = 1'b1;
          state_next = cap_en ? WAIT_FRAME : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A line already running when the frame opens is skipped until its next href_rise.
  assign in_frame = (state == IN_FRAME);
  assign capture  = in_frame & (line_active | href_rise) & pclk_rise & href_sync[1];
  assign line_end = in_frame & line_active & href_fall;

  always_comb begin
    push_en   = 1'b0;
    push_word = {hold_sof, 1'b0, hold_data};
    if (hold_valid && capture) begin
      push_en = 1'b1;
    end else if (hold_valid && line_end) begin
      push_en   = 1'b1;
      push_word = {hold_sof, 1'b1, hold_data};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      line_active  <= 1'b0;
      sof_pend     <= 1'b0;
      hold_valid   <= 1'b0;
      hold_sof     <= 1'b0;
      hold_data    <= '0;
      col_cnt      <= '0;
      col_cnt_last <= '0;
      line_cnt     <= '0;
      frame_cnt    <= '0;
    end else begin
      if (!in_frame)      line_active <= 1'b0;
      else if (href_rise) line_active <= 1'b1;
      else if (href_fall) line_active <= 1'b0;

      if (frame_start)  sof_pend <= 1'b1;
      else if (capture) sof_pend <= 1'b0;

      if (capture) begin
        hold_valid <= 1'b1;
        hold_data  <= data_s2;
        hold_sof   <= sof_pend;
      end else if (line_end || !in_frame) begin
        hold_valid <= 1'b0;
      end

      if (in_frame && href_rise)           col_cnt <= COL_W'(capture);
      else if (capture && col_cnt != '1)   col_cnt <= col_cnt + COL_W'(1);

      if (frame_start) line_cnt <= '0;
      else if (line_end) begin
        col_cnt_last <= col_cnt;
        if (line_cnt != '1) line_cnt <= line_cnt + ROW_W'(1);
      end

      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // A push at full is still taken when the head leaves in the same cycle.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = !empty && pix_ready;
  assign accept = push_en && (!full || pop);
  assign drop   = push_en && full && !pop;

  always_ff @(posedge wb_clk_i) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept)       wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)          rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign pix_valid = !empty;
  assign {pix_sof, pix_eol, pix_data} = pix_valid ? head : '0;

endmodule

// File: tb/tb_cis_dvp_capture.sv
// Directed bench for cis_dvp_capture: drives DVP frames, scoreboards the pixel stream
// against expected {sof, eol, data} words and checks the status counters.
module tb_cis_dvp_capture;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        cis_pclk = 1'b0;
  logic        cis_href = 1'b0;
  logic        cis_vsync = 1'b1;
  logic [9:0]  cis_data = '0;
  logic        cap_en = 1'b0;
  logic [9:0]  pix_data;
  logic        pix_sof, pix_eol, pix_valid;
  logic        pix_ready = 1'b0;
  logic [11:0] line_cnt, col_cnt_last;
  logic [7:0]  frame_cnt;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 1;
  logic        sof_next = 1'b0;
  logic [11:0] sb [$];
  logic        stalled = 1'b0;
  logic [11:0] stall_word = '0;

  cis_dvp_capture dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
    .cis_pclk(cis_pclk), .cis_href(cis_href), .cis_vsync(cis_vsync), .cis_data(cis_data),
    .cap_en(cap_en),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .line_cnt(line_cnt), .col_cnt_last(col_cnt_last), .frame_cnt(frame_cnt),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Ready changes just after the edge so the negedge monitor sees the value the DUT will use.
  always @(posedge wb_clk_i) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge wb_clk_i) begin
    logic [11:0] word;
    if (!wb_rst_n) begin
      stalled = 1'b0;
    end else begin
      word = {pix_sof, pix_eol, pix_data};
      if (stalled) check_output("stall_stable", {19'd0, pix_valid, word}, {19'd0, 1'b1, stall_word});
      if (pix_valid && pix_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("[TB] FAIL unexpected_pixel observed=%0h expected=none", word);
        end
        if (sb.size() > 0) check_output("pixel", 32'(word), 32'(sb.pop_front()));
        stalled = 1'b0;
      end else if (pix_valid) begin
        stalled    = 1'b1;
        stall_word = word;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic apply_pixel(input logic [9:0] v);
    cis_data = v;
    cis_href = 1'b1;
    #40 cis_pclk = 1'b1;
    #40 cis_pclk = 1'b0;
  endtask

  // keep = how many leading pixels of this line are expected to reach the output.
  task automatic apply_line(input int n, input int base, input int keep, input int drop_at, input bit finish);
    logic [9:0] v;
    for (int i = 0; i < n; i++) begin
      v = 10'(base + i);
      if (i == drop_at) cap_en = 1'b0;
      apply_pixel(v);
      if (i < keep) begin
        sb.push_back({sof_next, (finish && i == n - 1), v});
        sof_next = 1'b0;
      end
    end
    if (finish) begin
      cis_href = 1'b0;
      #200;
    end
  endtask

  task automatic apply_frame_start(input bit expect_capture);
    sof_next  = expect_capture;
    cis_vsync = 1'b0;
    #200;
  endtask

  task automatic apply_frame_end();
    cis_vsync = 1'b1;
    #300;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge wb_clk_i);
    check_output("rst_valid", 32'(pix_valid), 0);
    check_output("rst_data", 32'(pix_data), 0);
    check_output("rst_line_cnt", 32'(line_cnt), 0);
    check_output("rst_col_last", 32'(col_cnt_last), 0);
    check_output("rst_frame_cnt", 32'(frame_cnt), 0);
    check_output("rst_ovf", 32'(ovf), 0);
    wb_rst_n = 1'b1;
    #50;

    // 4x3 frame, ready high
    cap_en = 1'b1;
    ready_mode = 1;
    #50;
    apply_frame_start(1);
    for (int l = 0; l < 3; l++) apply_line(4, 1 + 4 * l, 4, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("f1_drained", 32'(sb.size()), 0);
    check_output("f1_line_cnt", 32'(line_cnt), 3);
    check_output("f1_col_last", 32'(col_cnt_last), 4);
    check_output("f1_frame_cnt", 32'(frame_cnt), 1);

    // overflow: 16-px line into 8-entry FIFO with ready low
    ready_mode = 0;
    #20;
    apply_frame_start(1);
    apply_line(16, 300, 8, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("ovf_valid", 32'(pix_valid), 1);
    check_output("ovf_set", 32'(ovf), 1);
    check_output("ovf_line_cnt", 32'(line_cnt), 1);
    check_output("ovf_col_last", 32'(col_cnt_last), 16);
    check_output("ovf_frame_cnt", 32'(frame_cnt), 2);
    ready_mode = 1;
    repeat (30) @(negedge wb_clk_i);
    check_output("ovf_drained", 32'(sb.size()), 0);
    check_output("ovf_empty", 32'(pix_valid), 0);
    check_output("ovf_still_set", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge wb_clk_i);
    ovf_clr = 1'b0;
    check_output("ovf_clr", 32'(ovf), 0);

    // cap_en raised mid-frame: that frame is skipped, the next one opens with sof
    cap_en = 1'b0;
    #50;
    apply_frame_start(0);
    apply_line(3, 500, 0, -1, 1);
    cap_en = 1'b1;
    apply_line(3, 510, 0, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("late_en_frame_cnt", 32'(frame_cnt), 2);
    check_output("late_en_valid", 32'(pix_valid), 0);
    apply_frame_start(1);
    apply_line(3, 520, 3, -1, 1);
    apply_line(3, 530, 3, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("late_en_drained", 32'(sb.size()), 0);
    check_output("late_en_frame_cnt2", 32'(frame_cnt), 3);
    check_output("late_en_line_cnt", 32'(line_cnt), 2);

    // cap_en dropped mid-line: frame completes, the following frame is ignored
    apply_frame_start(1);
    apply_line(4, 600, 4, 2, 1);
    apply_line(4, 610, 4, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("drop_en_frame_cnt", 32'(frame_cnt), 4);
    check_output("drop_en_drained", 32'(sb.size()), 0);
    apply_frame_start(0);
    apply_line(4, 620, 0, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("drop_en_idle_frame_cnt", 32'(frame_cnt), 4);
    check_output("drop_en_idle_valid", 32'(pix_valid), 0);

    // 640x2 frame under random backpressure
    cap_en = 1'b1;
    ready_mode = 2;
    #50;
    apply_frame_start(1);
    apply_line(640, 100, 640, -1, 1);
    apply_line(640, 900, 640, -1, 1);
    apply_frame_end();
    ready_mode = 1;
    repeat (20) @(negedge wb_clk_i);
    check_output("rand_drained", 32'(sb.size()), 0);
    check_output("rand_col_last", 32'(col_cnt_last), 640);
    check_output("rand_line_cnt", 32'(line_cnt), 2);
    check_output("rand_frame_cnt", 32'(frame_cnt), 5);
    check_output("rand_ovf", 32'(ovf), 0);

    // asynchronous reset mid-line
    ready_mode = 0;
    #20;
    apply_frame_start(0);
    apply_line(5, 40, 0, -1, 0);
    @(negedge wb_clk_i);
    check_output("pre_rst_valid", 32'(pix_valid), 1);
    @(posedge wb_clk_i);
    #3 wb_rst_n = 1'b0;
    #1;
    check_output("arst_valid", 32'(pix_valid), 0);
    check_output("arst_line_cnt", 32'(line_cnt), 0);
    check_output("arst_col_last", 32'(col_cnt_last), 0);
    check_output("arst_frame_cnt", 32'(frame_cnt), 0);
    sb.delete();
    #20 wb_rst_n = 1'b1;
    ready_mode = 1;
    apply_line(5, 45, 0, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("post_rst_no_frame", 32'(frame_cnt), 0);
    check_output("post_rst_valid", 32'(pix_valid), 0);
    apply_frame_start(1);
    apply_line(3, 200, 3, -1, 1);
    apply_frame_end();
    @(negedge wb_clk_i);
    check_output("post_rst_drained", 32'(sb.size()), 0);
    check_output("post_rst_frame_cnt", 32'(frame_cnt), 1);
    check_output("post_rst_col_last", 32'(col_cnt_last), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
